altlogic_host: RTL
==================

// Module: altlogic_host
// PURPOSE
// - Initiator for the 4-bit alternating AND/OR multicycle unit (start s, operands Ain/Bin, result C, done).
// - Accepts operand pairs on a valid/ready input stream, launches the unit, waits for done with timeout.
// - Captures the result and presents it on a valid/ready output stream. Sits between the host/test sequencer and the unit.
// PARAMETERS
// - NUM_BITS     4   operand/result width; must match the unit's width
// - TIMEOUT_CYC  32  max WAIT cycles before abort; must exceed unit latency (15 cycles at NUM_BITS=4)
// PORTS
// - clk        in   1         clock, all state on rising edge
// - reset      in   1         asynchronous, active-high
// - in_valid   in   1         operand pair valid
// - in_ready   out  1         block can accept operands
// - in_a       in   NUM_BITS  operand A
// - in_b       in   NUM_BITS  operand B
// - unit_s     out  1         start to unit
// - unit_ain   out  NUM_BITS  operand A to unit
// - unit_bin   out  NUM_BITS  operand B to unit
// - unit_c     in   NUM_BITS  result from unit
// - unit_done  in   1         unit completion, one-cycle level
// - out_valid  out  1         result valid
// - out_ready  in   1         consumer accepts result
// - out_c      out  NUM_BITS  captured result
// - out_tmo    out  1         result aborted by timeout, qualified by out_valid
// - mismatch   out  1         result differs from expected, qualified by out_valid
// - busy       out  1         state != IDLE
// BEHAVIOUR
// - Reset: state=IDLE; in_ready=1; unit_s=0; unit_ain=unit_bin=0; out_valid=0; out_c=0; out_tmo=0; mismatch=0; counter=0.
// - States: IDLE, LAUNCH, WAIT, HOLD.
// - IDLE: in_ready=1. On in_valid&in_ready, register in_a/in_b into op_a/op_b, go to LAUNCH.
// - LAUNCH: unit_s=1 for exactly one cycle; counter cleared; go to WAIT.
// - WAIT: unit_s=0; counter increments each cycle.
//   - On unit_done=1: register unit_c into out_c; out_tmo=0; go to HOLD.
//   - On counter==TIMEOUT_CYC-1 without done: out_c=0; out_tmo=1; go to HOLD.
//   - done and timeout in the same cycle: done wins.
// - HOLD: out_valid=1, out_c/out_tmo/mismatch stable. On out_ready go to IDLE; out_valid drops the next cycle.
// - unit_ain/unit_bin = op_a/op_b, held stable from LAUNCH through HOLD.
// - in_ready=0 in LAUNCH/WAIT/HOLD. Only one transaction is outstanding.
// - unit_done outside WAIT is ignored.
// - Latency: in handshake -> out_valid = unit latency + 2 cycles (17 at NUM_BITS=4).
// - Mid-operation reset clears everything to reset values. The unit shares this reset. No result is emitted for the aborted pair.
// CONFIGURATION
// - ALTLOGIC_HOST_CHECK_EN defined:
//   - expected = alt_ref(op_a, op_b), where bit i = a[i]&b[i] for even i and a[i]|b[i] for odd i.
//   - mismatch is registered with out_c: 1 if not timeout and unit_c != expected.
// - ALTLOGIC_HOST_CHECK_EN undefined: mismatch tied to 0 and no reference logic is built.
// STRUCTURE
// - altlogic_pkg contains:
//   - state enum {IDLE, LAUNCH, WAIT, HOLD}
//   - default NUM_BITS and TIMEOUT_CYC constants
//   - function alt_ref(a, b)
// - One sub-module, altlogic_ref_model: combinational expected-result generator. Instantiated only under the macro.
// - Counter width = $clog2(TIMEOUT_CYC+1).
// TESTING
// - a=4'b1100, b=4'b1010 against the real unit -> one unit_s pulse; out_c=4'b1010; out_tmo=0; out_valid 17 cycles after accept.
// - a=4'hF, b=4'hF then a=4'h0, b=4'hF back-to-back, out_ready=1 -> out_c=4'hF then 4'b1010, in order.
// - unit_done held 0 -> out_valid after 32 WAIT cycles with out_tmo=1, out_c=0; next pair accepted normally.
// - out_ready=0 for 5 cycles in HOLD -> out_valid/out_c stable; in_ready=0; in_valid ignored; unit_s stays 0.
// - reset asserted mid-WAIT -> all outputs at reset values at once; in_ready=1 after release; no stale out_valid.
// - CHECK_EN with a stub unit returning 4'h0 for a=4'hF, b=4'hF -> mismatch=1 with out_valid; real unit -> mismatch=0.

Source files
------------

// File: rtl/altlogic_pkg.sv
// altlogic_pkg: shared types, default sizing and the alternating AND/OR reference rule
// for the altlogic host and its optional expected-result generator.
package altlogic_pkg;

    localparam int ALT_NUM_BITS    = 4;
    localparam int ALT_TIMEOUT_CYC = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        HOLD   = 2'd3
    } alt_state_e;

    // Even bit positions combine with AND, odd positions with OR.
    function automatic logic alt_bit(input int idx, input logic a, input logic b);
        return idx[0] ? (a | b) : (a & b);
    endfunction

    function automatic logic [ALT_NUM_BITS-1:0] alt_ref(input logic [ALT_NUM_BITS-1:0] a,
                                                         input logic [ALT_NUM_BITS-1:0] b);
        logic [ALT_NUM_BITS-1:0] r;
        r = '0;
        for (int i = 0; i < ALT_NUM_BITS; i++) begin
            r[i] = alt_bit(i, a[i], b[i]);
        end
        return r;
    endfunction

endpackage

// File: rtl/altlogic_ref_model.sv
// altlogic_ref_model: combinational expected result for an operand pair, any width,
// built bit by bit from the package's alternating AND/OR rule.
module altlogic_ref_model
    import altlogic_pkg::*;
#(
    parameter int NUM_BITS = ALT_NUM_BITS
) (
    input  logic [NUM_BITS-1:0] i_op_a,
    input  logic [NUM_BITS-1:0] i_op_b,
    output logic [NUM_BITS-1:0] o_expected
);

    always_comb begin
        o_expected = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            o_expected[i] = alt_bit(i, i_op_a[i], i_op_b[i]);
        end
    end

endmodule

// File: rtl/altlogic_host.sv
// altlogic_host: valid/ready initiator that launches the alternating AND/OR unit, waits for
// done with a timeout and returns the result. Define ALTLOGIC_HOST_CHECK_EN for result checking.
module altlogic_host
    import altlogic_pkg::*;
#(
    parameter int NUM_BITS    = ALT_NUM_BITS,
    parameter int TIMEOUT_CYC = ALT_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [NUM_BITS-1:0] in_a,
    input  logic [NUM_BITS-1:0] in_b,
    output logic                unit_s,
    output logic [NUM_BITS-1:0] unit_ain,
    output logic [NUM_BITS-1:0] unit_bin,
    input  logic [NUM_BITS-1:0] unit_c,
    input  logic                unit_done,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [NUM_BITS-1:0] out_c,
    output logic                out_tmo,
    output logic                mismatch,
    output logic                busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
    // the producer holds valid and its data stable until that edge.
    alt_state_e          r_state;
    alt_state_e          w_next;
    logic                w_accept;
    logic                w_done_cap;
    logic                w_tmo_cap;
    logic [NUM_BITS-1:0] r_op_a;
    logic [NUM_BITS-1:0] r_op_b;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_BITS-1:0] r_out_c;
    logic                r_out_tmo;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_accept   = 1'b0;
        w_done_cap = 1'b0;
        w_tmo_cap  = 1'b0;
        in_ready   = 1'b0;
        unit_s     = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = LAUNCH;
                end
            end
            LAUNCH: begin
                unit_s = 1'b1;
                w_next = WAIT;
            end
            WAIT: begin
                // A done arriving on the last allowed cycle still counts as a real result.
                if (unit_done) begin
                    w_done_cap = 1'b1;
                    w_next     = HOLD;
                end else if (r_cnt == CNT_LAST) begin
                    w_tmo_cap = 1'b1;
                    w_next    = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_cnt     <= '0;
            r_out_c   <= '0;
            r_out_tmo <= 1'b0;
        end else begin
            if (w_accept) begin
                r_op_a <= in_a;
                r_op_b <= in_b;
            end
            if (r_state == LAUNCH) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_done_cap) begin
                r_out_c   <= unit_c;
                r_out_tmo <= 1'b0;
            end else if (w_tmo_cap) begin
                r_out_c   <= '0;
                r_out_tmo <= 1'b1;
            end
        end
    end

    assign unit_ain = r_op_a;
    assign unit_bin = r_op_b;
    assign out_c    = r_out_c;
    assign out_tmo  = r_out_tmo;

`ifdef ALTLOGIC_HOST_CHECK_EN
    logic [NUM_BITS-1:0] w_expected;
    logic                r_mismatch;

    altlogic_ref_model #(
        .NUM_BITS (NUM_BITS)
    ) u_ref_model (
        .i_op_a     (r_op_a),
        .i_op_b     (r_op_b),
        .o_expected (w_expected)
    );

    // Registered alongside out_c so it is qualified by the same out_valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mismatch <= 1'b0;
        end else if (w_done_cap) begin
            r_mismatch <= (unit_c != w_expected);
        end else if (w_tmo_cap) begin
            r_mismatch <= 1'b0;
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

endmodule
